// File: rtl/shared_reg_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : shared_reg_arbiter_if
// Description : Bundles the requester-side signals of the shared-register
//               arbiter. The slave modport belongs to the arbiter and the
//               master modport belongs to the requester side.
//               Signals:
//                 req          - per-requester level request (4 bits)
//                 data_in      - requester data, requester i on [i*N +: N]
//                 grant        - one-hot registered grant (4 bits)
//                 grant_id     - index of current/last grantee (2 bits)
//                 busy         - arbiter in LOAD or HOLD
//                 reg_en       - shared register load strobe (LOAD only)
//                 data_out     - shared register contents (N bits)
//                 timeout_flag - sticky forced-release flag
// Revision    : 1.0 - initial release
// ============================================================================
interface shared_reg_arbiter_if #(
   parameter int N = 8
);
   logic [3:0]     req;
   logic [4*N-1:0] data_in;
   logic [3:0]     grant;
   logic [1:0]     grant_id;
   logic           busy;
   logic           reg_en;
   logic [N-1:0]   data_out;
   logic           timeout_flag;

   modport master (
      output req,
      output data_in,
      input  grant,
      input  grant_id,
      input  busy,
      input  reg_en,
      input  data_out,
      input  timeout_flag
   );

   modport slave (
      input  req,
      input  data_in,
      output grant,
      output grant_id,
      output busy,
      output reg_en,
      output data_out,
      output timeout_flag
   );
endinterface
`default_nettype wire

// File: rtl/shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shared_reg_arbiter
// Description : Round-robin arbiter and sequencer sharing one N-bit register
//               between four requesters. A winner is picked in IDLE, its data
//               slice is loaded into the shared register in LOAD, ownership is
//               held in HOLD until the requester drops its request, and then
//               priority rotates to the requester after the released one.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset
//               bus  - shared_reg_arbiter_if.slave (req, data_in, grant,
//                      grant_id, busy, reg_en, data_out, timeout_flag)
// Parameters  : N       - data width of each requester and of the register
//               TIMEOUT - max HOLD cycles before a forced release
// Config      : `define ARB_TIMEOUT_EN enables the HOLD timeout counter and
//               the sticky timeout_flag; without it ownership is unbounded
//               and timeout_flag is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module shared_reg_arbiter #(
   parameter int N       = 8,
   parameter int TIMEOUT = 16
) (
   input  wire logic          clk,
   input  wire logic          rst,
   shared_reg_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------------
   state_t       r_state;
   logic [3:0]   r_grant;
   logic [1:0]   r_grant_id;
   logic [1:0]   r_last;
   logic [N-1:0] r_data;

   // ------------------------------------------------------------------------
   // Next-state values and helpers
   // ------------------------------------------------------------------------
   state_t       w_state_nxt;
   logic [3:0]   w_grant_nxt;
   logic [1:0]   w_grant_id_nxt;
   logic [1:0]   w_last_nxt;
   logic [N-1:0] w_data_nxt;

   logic         w_win_valid;
   logic [1:0]   w_win_id;
   logic [N-1:0] w_sel_data;
   logic         w_timeout_hit;
   logic         w_release;

   // ------------------------------------------------------------------------
   // Round-robin winner search. The scan starts at last+1 and wraps; it runs
   // from the farthest candidate down to the nearest so the nearest requesting
   // candidate is the one left in w_win_id.
   // ------------------------------------------------------------------------
   always_comb begin
      w_win_valid = 1'b0;
      w_win_id    = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         logic [1:0] cand;
         cand = r_last + 2'(k);
         if (bus.req[cand]) begin
            w_win_valid = 1'b1;
            w_win_id    = cand;
         end
      end
   end

   // 4:1 select of the granted requester's data slice.
   assign w_sel_data = bus.data_in[r_grant_id*N +: N];

   // Ownership ends when the owner drops its request or the timeout fires.
   assign w_release = ~bus.req[r_grant_id] | w_timeout_hit;

   // ------------------------------------------------------------------------
   // Next-state / next-value logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_grant_nxt    = r_grant;
      w_grant_id_nxt = r_grant_id;
      w_last_nxt     = r_last;
      w_data_nxt     = r_data;

      unique case (r_state)
         S_IDLE: begin
            if (w_win_valid) begin
               w_state_nxt    = S_LOAD;
               w_grant_nxt    = 4'b0001 << w_win_id;
               w_grant_id_nxt = w_win_id;
            end
         end

         // LOAD always completes, even if the request already dropped; the
         // following HOLD cycle then performs the release.
         S_LOAD: begin
            w_data_nxt  = w_sel_data;
            w_state_nxt = S_HOLD;
         end

         S_HOLD: begin
            if (w_release) begin
               w_state_nxt = S_IDLE;
               w_grant_nxt = 4'b0000;
               w_last_nxt  = r_grant_id;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = 4'b0000;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_grant    <= 4'b0000;
         r_grant_id <= 2'd0;
         r_last     <= 2'd3;          // requester 0 wins the first contention
         r_data     <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_grant    <= w_grant_nxt;
         r_grant_id <= w_grant_id_nxt;
         r_last     <= w_last_nxt;
         r_data     <= w_data_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Optional HOLD timeout
   // ------------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   // The counter reads TIMEOUT-1 during the TIMEOUT-th HOLD cycle, so the
   // release happens at the end of exactly TIMEOUT HOLD cycles.
   localparam logic [CW-1:0] c_hold_last = CW'(TIMEOUT - 1);

   logic [CW-1:0] r_hold_cnt;
   logic          r_timeout_flag;
   logic          w_timeout_force;

   assign w_timeout_hit   = (r_state == S_HOLD) && (r_hold_cnt == c_hold_last);
   // Only a release the owner did not ask for counts as forced.
   assign w_timeout_force = w_timeout_hit & bus.req[r_grant_id];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold_cnt     <= '0;
         r_timeout_flag <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && w_win_valid) begin
            r_hold_cnt <= '0;
         end else if (r_state == S_HOLD) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
         end
         if (w_timeout_force) begin
            r_timeout_flag <= 1'b1;
         end
      end
   end

   assign bus.timeout_flag = r_timeout_flag;
`else
   localparam int c_unused_timeout = TIMEOUT;

   assign w_timeout_hit    = 1'b0;
   assign bus.timeout_flag = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.grant    = r_grant;
   assign bus.grant_id = r_grant_id;
   assign bus.busy     = (r_state != S_IDLE);
   assign bus.reg_en   = (r_state == S_LOAD);
   assign bus.data_out = r_data;

   // ------------------------------------------------------------------------
   // Structural invariants
   // ------------------------------------------------------------------------
   a_grant_onehot0: assert property (@(posedge clk) disable iff (rst)
      $onehot0(r_grant));

   a_idle_no_grant: assert property (@(posedge clk) disable iff (rst)
      (r_state == S_IDLE) |-> (r_grant == 4'b0000));

endmodule
`default_nettype wire

// File: tb/tb_shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_shared_reg_arbiter
// Description : Self-checking bench for shared_reg_arbiter. A cycle-by-cycle
//               vector table covers reset, single request, early drop,
//               round-robin start point, ignored non-granted requests and
//               mid-operation reset; hand-written sequences cover rotation
//               and HOLD ownership length (timeout when ARB_TIMEOUT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_reg_arbiter;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   shared_reg_arbiter_if #(.N(8)) bus ();

   shared_reg_arbiter #(
      .N       (8),
      .TIMEOUT (4)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Vector: inputs applied before an edge, outputs expected after it.
   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] grant;
      logic [1:0] id;
      logic       busy;
      logic       reg_en;
      logic [7:0] data;
   } vec_t;

   vec_t vecs[23];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [16:0] snap();
      return {bus.grant, bus.grant_id, bus.busy, bus.reg_en, bus.data_out, bus.timeout_flag};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // slice0=11, slice1=22, slice2=A5, slice3=44
      bus.data_in = 32'h44A5_2211;
      bus.req     = 4'b0000;
      rst         = 1'b1;

      //            rst   req      grant    id    busy  ren   data
      vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00}; // reset, req held
      vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00};
      vecs[2]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1, 8'h00}; // req0 wins first
      vecs[3]  = '{1'b0, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 8'h11}; // drop in LOAD, still loads
      vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h11}; // release
      vecs[5]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 8'h11}; // single request 2
      vecs[6]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 8'hA5};
      vecs[7]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 8'hA5};
      vecs[8]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 8'hA5}; // release, data kept
      vecs[9]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 8'hA5};
      vecs[10] = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, 8'hA5}; // 1-cycle pulse on req1
      vecs[11] = '{1'b0, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0, 8'h22};
      vecs[12] = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 8'h22}; // busy was 2 cycles
      vecs[13] = '{1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1, 1'b1, 8'h22}; // last=1 -> 3 beats 0,1
      vecs[14] = '{1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1, 1'b0, 8'h44};
      vecs[15] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, 8'h44}; // others drop: ignored
      vecs[16] = '{1'b0, 4'b0010, 4'b0000, 2'd3, 1'b0, 1'b0, 8'h44}; // owner drops
      vecs[17] = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, 8'h44};
      vecs[18] = '{1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0, 8'h22}; // HOLD, grant 0010
      vecs[19] = '{1'b1, 4'b0011, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00}; // mid-HOLD reset
      vecs[20] = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b1, 8'h00}; // restarts at requester 0
      vecs[21] = '{1'b0, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 8'h11};
      vecs[22] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h11};

      for (int i = 0; i < 23; i++) begin
         rst     = vecs[i].rst;
         bus.req = vecs[i].req;
         tick();
         check($sformatf("vec%0d{grant,id,busy,ren,data,tflag}", i), 32'(snap()),
               32'({vecs[i].grant, vecs[i].id, vecs[i].busy, vecs[i].reg_en, vecs[i].data, 1'b0}));
      end

      // ---------------- Rotation: all requesting, each owner keeps 3 HOLD cycles
      rst     = 1'b1;
      bus.req = 4'b0000;
      tick();
      rst     = 1'b0;
      bus.req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         int exp_id;
         int waited;
         exp_id = n % 4;
         waited = 0;
         while (bus.grant == 4'b0000 && waited < 8) begin
            tick();
            waited++;
         end
         check($sformatf("rot%0d_grant", n), 32'(bus.grant), 32'(4'b0001 << exp_id));
         for (int h = 0; h < 3; h++) begin
            tick();
            check($sformatf("rot%0d_hold%0d_onehot", n, h), 32'($onehot(bus.grant)), 32'd1);
         end
         bus.req[exp_id] = 1'b0;
         tick();
         check($sformatf("rot%0d_release", n), 32'({bus.grant, bus.busy}), 32'd0);
         bus.req = 4'b1111;
      end

`ifdef ARB_TIMEOUT_EN
      // ---------------- Timeout: make requester 3 owner, keep it asserted
      rst     = 1'b1;
      bus.req = 4'b0000;
      tick();
      rst     = 1'b0;
      bus.req = 4'b0100;
      tick();                                   // LOAD for 2
      tick();                                   // HOLD
      bus.req = 4'b0000;
      tick();                                   // release, last = 2
      bus.req = 4'b1001;
      tick();
      check("to_grant3", 32'(bus.grant), 32'(4'b1000));
      for (int h = 1; h <= 4; h++) begin
         tick();
         check($sformatf("to_hold%0d", h), 32'({bus.grant, bus.timeout_flag}), 32'({4'b1000, 1'b0}));
      end
      tick();
      check("to_forced_release", 32'({bus.grant, bus.busy, bus.timeout_flag}),
            32'({4'b0000, 1'b0, 1'b1}));
      tick();
      check("to_next_grant0", 32'({bus.grant, bus.timeout_flag}), 32'({4'b0001, 1'b1}));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("to_flag_cleared", 32'(bus.timeout_flag), 32'd0);
`else
      // ---------------- Unbounded ownership: requester 3 keeps grant indefinitely
      rst     = 1'b1;
      bus.req = 4'b0000;
      tick();
      rst     = 1'b0;
      bus.req = 4'b1000;
      tick();
      check("hold_grant3", 32'(bus.grant), 32'(4'b1000));
      bus.req = 4'b1001;
      for (int h = 0; h < 20; h++) tick();
      check("hold_long", 32'({bus.grant, bus.busy, bus.timeout_flag}), 32'({4'b1000, 1'b1, 1'b0}));
      bus.req = 4'b0001;
      tick();
      tick();
      check("hold_next_grant0", 32'(bus.grant), 32'(4'b0001));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
